// File: rtl/mem_port_if.sv
// One memory port: request fields flow master -> slave, grant and response flow back.
interface mem_port_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, wen, strb, wdata, input  gnt, err, rdata);
    modport slave  (input  req, addr, wen, strb, wdata, output gnt, err, rdata);
endinterface

// File: rtl/mem_if_arbiter.sv
// Round-robin merge of the fetch (imem) and data (dmem) ports onto one memory port,
// holding a stalled request stable until granted and steering responses back by port.
module mem_if_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic       g_clk,
    input  logic       g_reset,
    mem_port_if.slave  imem,
    mem_port_if.slave  dmem,
    mem_port_if.master mem
);
    typedef enum logic { UNLOCKED = 1'b0, LOCKED = 1'b1 } lock_state_e;
    typedef enum logic { PORT_I = 1'b0, PORT_D = 1'b1 } port_e;

    lock_state_e lock_state_q, lock_state_d;
    port_e       lock_id_q, lock_id_d;
    port_e       pri_q, pri_d;
    logic        rsp_v_q, rsp_v_d;
    port_e       rsp_id_q, rsp_id_d;

    port_e             sel;
    logic              req_act;
    logic              hit;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wen;
    logic [STRB_W-1:0] sel_strb;
    logic [DATA_W-1:0] sel_wdata;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        sel     = pri_q;
        req_act = 1'b0;
        if (lock_state_q == LOCKED) begin
            sel     = lock_id_q;
            req_act = (lock_id_q == PORT_D) ? dmem.req : imem.req;
        end else if (imem.req && dmem.req) begin
            sel     = pri_q;
            req_act = 1'b1;
        end else if (dmem.req) begin
            sel     = PORT_D;
            req_act = 1'b1;
        end else if (imem.req) begin
            sel     = PORT_I;
            req_act = 1'b1;
        end
        // Reset must silence memory even while requestors keep their req high.
        if (g_reset) req_act = 1'b0;
        hit = req_act && mem.gnt;

        sel_addr  = '0;
        sel_wen   = 1'b0;
        sel_strb  = '0;
        sel_wdata = '0;
        if (req_act) begin
            sel_addr  = (sel == PORT_D) ? dmem.addr  : imem.addr;
            sel_wen   = (sel == PORT_D) ? dmem.wen   : imem.wen;
            sel_strb  = (sel == PORT_D) ? dmem.strb  : imem.strb;
            sel_wdata = (sel == PORT_D) ? dmem.wdata : imem.wdata;
        end

        lock_state_d = lock_state_q;
        lock_id_d    = lock_id_q;
        unique case (lock_state_q)
            UNLOCKED: if (req_act && !mem.gnt) begin
                lock_state_d = LOCKED;
                lock_id_d    = sel;
            end
            LOCKED:   if (!req_act || mem.gnt) lock_state_d = UNLOCKED;
            default:  lock_state_d = UNLOCKED;
        endcase

        pri_d    = hit ? port_e'(~sel) : pri_q;
        rsp_v_d  = hit;
        rsp_id_d = sel;
    end

    assign mem.req   = req_act;
    assign mem.addr  = sel_addr;
    assign mem.wen   = sel_wen;
    assign mem.strb  = sel_strb;
    assign mem.wdata = sel_wdata;

    assign imem.gnt   = hit && (sel == PORT_I);
    assign dmem.gnt   = hit && (sel == PORT_D);
    assign imem.err   = rsp_v_q && (rsp_id_q == PORT_I) && mem.err;
    assign dmem.err   = rsp_v_q && (rsp_id_q == PORT_D) && mem.err;
    assign imem.rdata = (rsp_v_q && rsp_id_q == PORT_I) ? mem.rdata : '0;
    assign dmem.rdata = (rsp_v_q && rsp_id_q == PORT_D) ? mem.rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lock_state_q <= UNLOCKED;
            lock_id_q    <= PORT_I;
            pri_q        <= PORT_D;
            rsp_v_q      <= 1'b0;
            rsp_id_q     <= PORT_I;
        end else begin
            lock_state_q <= lock_state_d;
            lock_id_q    <= lock_id_d;
            pri_q        <= pri_d;
            rsp_v_q      <= rsp_v_d;
            rsp_id_q     <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_mem_if_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_if_arbiter;
    logic g_clk = 1'b0;
    logic g_reset;
    int   checks = 0;
    int   failures = 0;

    mem_port_if imem_if ();
    mem_port_if dmem_if ();
    mem_port_if mem_if ();

    mem_if_arbiter dut (
        .g_clk  (g_clk),
        .g_reset(g_reset),
        .imem   (imem_if),
        .dmem   (dmem_if),
        .mem    (mem_if)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a presented-but-ungranted request stays owner of the port; ties go to pref;
    // a granted request's response comes back on the next cycle to the same port.
    bit m_locked = 1'b0;
    bit m_lock_port = 1'b0;   // 0 = imem, 1 = dmem
    bit m_pref = 1'b1;
    bit m_rsp_valid = 1'b0;
    bit m_rsp_port = 1'b0;

    always @(negedge g_clk) begin
        bit p, r, g;
        if (g_reset) begin
            check("rst_mem_req", mem_if.req, 0);
            check("rst_mem_addr", mem_if.addr, 0);
            check("rst_imem_gnt", imem_if.gnt, 0);
            check("rst_dmem_gnt", dmem_if.gnt, 0);
            check("rst_imem_err", imem_if.err, 0);
            check("rst_dmem_err", dmem_if.err, 0);
            check("rst_imem_rdata", imem_if.rdata, 0);
            check("rst_dmem_rdata", dmem_if.rdata, 0);
            m_locked = 1'b0; m_pref = 1'b1; m_rsp_valid = 1'b0;
        end else begin
            if (m_locked) begin
                p = m_lock_port;
                r = m_lock_port ? dmem_if.req : imem_if.req;
            end else if (imem_if.req && dmem_if.req) begin
                p = m_pref; r = 1'b1;
            end else begin
                p = dmem_if.req; r = imem_if.req || dmem_if.req;
            end
            g = r && mem_if.gnt;
            check("m_mem_req", mem_if.req, r);
            if (r) begin
                check("m_mem_addr", mem_if.addr, p ? dmem_if.addr : imem_if.addr);
                check("m_mem_wen", mem_if.wen, p ? dmem_if.wen : imem_if.wen);
                check("m_mem_strb", mem_if.strb, p ? dmem_if.strb : imem_if.strb);
                check("m_mem_wdata", mem_if.wdata, p ? dmem_if.wdata : imem_if.wdata);
            end
            check("m_imem_gnt", imem_if.gnt, g && !p);
            check("m_dmem_gnt", dmem_if.gnt, g && p);
            check("m_imem_rdata", imem_if.rdata, (m_rsp_valid && !m_rsp_port) ? mem_if.rdata : 64'd0);
            check("m_dmem_rdata", dmem_if.rdata, (m_rsp_valid && m_rsp_port) ? mem_if.rdata : 64'd0);
            check("m_imem_err", imem_if.err, m_rsp_valid && !m_rsp_port && mem_if.err);
            check("m_dmem_err", dmem_if.err, m_rsp_valid && m_rsp_port && mem_if.err);
            m_rsp_valid = g;
            m_rsp_port  = p;
            if (g) m_pref = !p;
            m_locked    = r && !mem_if.gnt;
            m_lock_port = p;
        end
    end

    task automatic drive(bit ir, logic [63:0] ia, bit dr, logic [63:0] da, bit gnt);
        imem_if.req  = ir;
        imem_if.addr = ia;
        dmem_if.req  = dr;
        dmem_if.addr = da;
        mem_if.gnt   = gnt;
    endtask

    task automatic mid();   // after the model checks of the current cycle
        @(negedge g_clk);
        #1;
    endtask

    task automatic next();  // into the next cycle, away from the edge
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        bit exp_d;
        g_reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        imem_if.wen = 0; imem_if.strb = 0; imem_if.wdata = 0;
        dmem_if.wen = 0; dmem_if.strb = 0; dmem_if.wdata = 0;
        mem_if.err = 0;  mem_if.rdata = 0;
        repeat (2) next();
        mid();
        check("reset_mem_req", mem_if.req, 0);
        next();
        g_reset = 1'b0;

        // Tie after reset: dmem, imem, dmem, imem.
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h100, 1, 64'h200, 1);
            mid();
            exp_d = (i % 2 == 0);
            check("tie_dmem_gnt", dmem_if.gnt, exp_d);
            check("tie_imem_gnt", imem_if.gnt, !exp_d);
            next();
        end
        drive(0, 0, 0, 0, 0);
        next();

        // Single dmem read.
        drive(0, 0, 1, 64'h1000, 1);
        mid();
        check("single_mem_addr", mem_if.addr, 64'h1000);
        check("single_dmem_gnt", dmem_if.gnt, 1);
        check("single_imem_gnt", imem_if.gnt, 0);
        next();
        drive(0, 0, 0, 0, 0);
        mem_if.rdata = 64'hDEAD_BEEF;
        mid();
        check("single_dmem_rdata", dmem_if.rdata, 64'hDEAD_BEEF);
        check("single_imem_rdata", imem_if.rdata, 0);
        next();

        // Stall lock: imem write at 0x40 held while dmem arrives.
        imem_if.wen = 1; imem_if.strb = 8'h0F; imem_if.wdata = 64'hAA55;
        dmem_if.wen = 0; dmem_if.strb = 8'hFF; dmem_if.wdata = 64'h1111;
        mem_if.rdata = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1, 64'h40, c >= 1, 64'h2000, c == 3);
            mid();
            check("stall_mem_addr", mem_if.addr, 64'h40);
            check("stall_mem_wen", mem_if.wen, 1);
            check("stall_mem_strb", mem_if.strb, 64'h0F);
            check("stall_mem_wdata", mem_if.wdata, 64'hAA55);
            check("stall_dmem_gnt", dmem_if.gnt, 0);
            check("stall_imem_gnt", imem_if.gnt, c == 3);
            next();
        end
        drive(0, 0, 1, 64'h2000, 1);
        mem_if.rdata = 64'h1234;
        mid();
        check("stall_dmem_gnt4", dmem_if.gnt, 1);
        check("stall_mem_addr4", mem_if.addr, 64'h2000);
        check("stall_imem_rdata", imem_if.rdata, 64'h1234);
        check("stall_dmem_rdata", dmem_if.rdata, 0);
        next();

        // Error steering for the dmem grant above.
        drive(0, 0, 0, 0, 0);
        mem_if.err = 1; mem_if.rdata = 64'h55;
        mid();
        check("err_dmem_err", dmem_if.err, 1);
        check("err_imem_err", imem_if.err, 0);
        check("err_dmem_rdata", dmem_if.rdata, 64'h55);
        next();
        mem_if.err = 0; mem_if.rdata = 0;
        imem_if.wen = 0;

        // Dropped locked request.
        drive(1, 64'h80, 0, 0, 0);
        mid();
        check("drop_mem_req0", mem_if.req, 1);
        next();
        drive(0, 64'h80, 1, 64'h3000, 1);
        mid();
        check("drop_mem_req1", mem_if.req, 0);
        check("drop_imem_gnt1", imem_if.gnt, 0);
        check("drop_dmem_gnt1", dmem_if.gnt, 0);
        next();
        mid();
        check("drop_dmem_gnt2", dmem_if.gnt, 1);
        check("drop_mem_addr2", mem_if.addr, 64'h3000);
        next();
        drive(0, 0, 0, 0, 0);
        next();

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 1'($urandom));
            imem_if.wen = 1'($urandom); imem_if.strb = 8'($urandom); imem_if.wdata = {$urandom, $urandom};
            dmem_if.wen = 1'($urandom); dmem_if.strb = 8'($urandom); dmem_if.wdata = {$urandom, $urandom};
            mem_if.err = 1'($urandom); mem_if.rdata = {$urandom, $urandom};
            next();
        end
        drive(0, 0, 0, 0, 0);
        mem_if.err = 0; mem_if.rdata = 0;
        next();

        // Reset while a locked imem request is in flight.
        drive(1, 64'h500, 0, 0, 0);
        next();
        drive(1, 64'h500, 1, 64'h600, 1);
        mem_if.rdata = 64'hFFFF; mem_if.err = 1;
        g_reset = 1'b1;
        #1;
        check("rstlock_mem_req", mem_if.req, 0);
        check("rstlock_imem_gnt", imem_if.gnt, 0);
        check("rstlock_dmem_gnt", dmem_if.gnt, 0);
        check("rstlock_imem_rdata", imem_if.rdata, 0);
        check("rstlock_dmem_err", dmem_if.err, 0);
        next();
        g_reset = 1'b0;
        mem_if.rdata = 0; mem_if.err = 0;
        mid();
        check("post_rst_dmem_gnt", dmem_if.gnt, 1);
        check("post_rst_imem_gnt", imem_if.gnt, 0);
        next();
        mid();
        check("post_rst_imem_gnt2", imem_if.gnt, 1);
        next();
        drive(0, 0, 0, 0, 0);
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
